// File: rtl/load_store_unit.sv
// Load/store unit between execute and a 64-word data memory: byte/halfword
// extraction with sign/zero extension, sub-word stores as read-modify-write.
module load_store_unit #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              done,
    output logic              busy,
    output logic              fault,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RMW_RD = 3'd2,
        WRITE  = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    state_t            state_reg;
    logic              we_reg;
    logic [2:0]        funct3_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [31:0]       wdata_reg;
    logic [31:0]       merged_reg;
    logic [31:0]       rdata_reg;
    logic              fault_reg;

    logic              req_fault;
    logic [31:0]       load_next;
    logic [31:0]       merged_next;
    logic [31:0]       lane_shifted;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;

    // Fault classification of the incoming request, evaluated only in IDLE.
    always_comb begin
        req_fault = 1'b0;
        if (we) begin
            if (funct3 > F3_W)
                req_fault = 1'b1;
            else if (funct3 == F3_H && addr[0])
                req_fault = 1'b1;
            else if (funct3 == F3_W && addr[1:0] != 2'b00)
                req_fault = 1'b1;
        end else begin
            case (funct3)
                F3_B, F3_BU: req_fault = 1'b0;
                F3_H, F3_HU: req_fault = addr[0];
                F3_W:        req_fault = (addr[1:0] != 2'b00);
                default:     req_fault = 1'b1;
            endcase
        end
    end

    // Lane selection and extension for loads.
    always_comb begin
        lane_shifted = mem_rdata >> {addr_reg[1:0], 3'b000};
        byte_sel     = lane_shifted[7:0];
        half_sel     = addr_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_reg)
            F3_B:    load_next = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_next = {24'd0, byte_sel};
            F3_H:    load_next = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_next = {16'd0, half_sel};
            default: load_next = mem_rdata;
        endcase
    end

    // Per-lane merge for SB/SH: odd lanes of a halfword take wdata[15:8].
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_merge
            logic lane_hit;
            assign lane_hit = (funct3_reg == F3_B && addr_reg[1:0] == gi[1:0]) ||
                              (funct3_reg == F3_H && addr_reg[1] == gi[1]);
            assign merged_next[8*gi+7:8*gi] = !lane_hit ? mem_rdata[8*gi+7:8*gi] :
                                              (funct3_reg == F3_H && gi[0]) ? wdata_reg[15:8] :
                                              wdata_reg[7:0];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            we_reg     <= 1'b0;
            funct3_reg <= 3'd0;
            addr_reg   <= '0;
            wdata_reg  <= 32'd0;
            merged_reg <= 32'd0;
            rdata_reg  <= 32'd0;
            fault_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req) begin
                        we_reg     <= we;
                        funct3_reg <= funct3;
                        addr_reg   <= addr;
                        wdata_reg  <= wdata;
                        fault_reg  <= req_fault;
                        if (req_fault)
                            state_reg <= DONE;
                        else if (!we)
                            state_reg <= LOAD;
                        else if (funct3 == F3_W)
                            state_reg <= WRITE;
                        else
                            state_reg <= RMW_RD;
                    end
                end
                LOAD: begin
                    rdata_reg <= load_next;
                    state_reg <= DONE;
                end
                RMW_RD: begin
                    merged_reg <= merged_next;
                    state_reg  <= WRITE;
                end
                WRITE:   state_reg <= DONE;
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Strobes decode straight from state so an asynchronous reset kills them at once.
    assign busy      = (state_reg == LOAD) || (state_reg == RMW_RD) || (state_reg == WRITE);
    assign mem_read  = (state_reg == LOAD) || (state_reg == RMW_RD);
    assign mem_write = (state_reg == WRITE);
    assign done      = (state_reg == DONE);
    assign fault     = fault_reg;
    assign rdata     = rdata_reg;
    assign mem_addr  = addr_reg[ADDR_W-1:2];
    assign mem_wdata = (state_reg != WRITE) ? 32'd0 :
                       (we_reg && funct3_reg == F3_W) ? wdata_reg : merged_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural 64-word memory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [7:0]  addr = 8'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        done, busy, fault, mem_read, mem_write;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:63];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3), .addr(addr),
        .wdata(wdata), .rdata(rdata), .done(done), .busy(busy), .fault(fault),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // One access from IDLE; reports cycles to done and memory strobe counts.
    task automatic do_access(input string tag, input logic w, input logic [2:0] f,
                             input logic [7:0] a, input logic [31:0] d,
                             output int lat, output int nrd, output int nwr, output logic flt);
        int both;
        @(negedge clk);
        req = 1'b1; we = w; funct3 = f; addr = a; wdata = d;
        @(posedge clk);
        #1 req = 1'b0;
        lat = 0; nrd = 0; nwr = 0; both = 0; flt = 1'b0;
        while (1) begin
            @(negedge clk);
            lat++;
            if (mem_read) nrd++;
            if (mem_write) nwr++;
            if (mem_read && mem_write) both++;
            if (done) begin
                flt = fault;
                break;
            end
            if (lat >= 10) begin
                check_eq({tag, "_timeout"}, 32'(lat), 32'd0);
                break;
            end
        end
        check_eq({tag, "_rw_overlap"}, 32'(both), 32'd0);
        $display("txn %-6s we=%0b f3=%0d addr=%h wdata=%h -> lat=%0d rd=%0d wr=%0d fault=%0b rdata=%h",
                 tag, w, f, a, d, lat, nrd, nwr, flt, rdata);
    endtask

    int lat, nrd, nwr;
    logic flt;
    logic [4:0] busy_tr, done_tr;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[1] = 32'h876543F1;

        // Reset state
        #12;
        check_eq("rst_strobes", {27'd0, done, busy, fault, mem_read, mem_write}, 32'd0);
        check_eq("rst_rdata", rdata, 32'd0);
        check_eq("rst_maddr", {26'd0, mem_addr}, 32'd0);
        check_eq("rst_mwdata", mem_wdata, 32'd0);
        @(negedge clk) rst = 1'b1;

        // Reset in the middle of SB 0x05
        @(negedge clk);
        req = 1'b1; we = 1'b1; funct3 = 3'd0; addr = 8'h05; wdata = 32'h123456AA;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        check_eq("rmw_rd_phase", {30'd0, mem_read, mem_write}, 32'd2);
        @(negedge clk);
        check_eq("write_phase", {30'd0, mem_read, mem_write}, 32'd1);
        rst = 1'b0;
        #1;
        check_eq("abort_strobes", {27'd0, done, busy, fault, mem_read, mem_write}, 32'd0);
        check_eq("abort_mwdata", mem_wdata, 32'd0);
        check_eq("abort_maddr", {26'd0, mem_addr}, 32'd0);
        @(posedge clk);
        #1 check_eq("abort_mem1", mem[1], 32'h876543F1);
        $display("txn abort  SB 0x05 reset during WRITE -> mem[1]=%h", mem[1]);
        @(negedge clk) rst = 1'b1;

        // Loads
        do_access("LW04", 1'b0, 3'd2, 8'h04, 32'h0, lat, nrd, nwr, flt);
        check_eq("LW04_rdata", rdata, 32'h876543F1);
        check_eq("LW04_lat", 32'(lat), 32'd2);
        check_eq("LW04_rd", 32'(nrd), 32'd1);
        check_eq("LW04_fault", {31'd0, flt}, 32'd0);
        do_access("LB04", 1'b0, 3'd0, 8'h04, 32'h0, lat, nrd, nwr, flt);
        check_eq("LB04_rdata", rdata, 32'hFFFFFFF1);
        do_access("LBU07", 1'b0, 3'd4, 8'h07, 32'h0, lat, nrd, nwr, flt);
        check_eq("LBU07_rdata", rdata, 32'h00000087);
        do_access("LH06", 1'b0, 3'd1, 8'h06, 32'h0, lat, nrd, nwr, flt);
        check_eq("LH06_rdata", rdata, 32'hFFFF8765);
        do_access("LHU06", 1'b0, 3'd5, 8'h06, 32'h0, lat, nrd, nwr, flt);
        check_eq("LHU06_rdata", rdata, 32'h00008765);

        // Sub-word stores
        do_access("SB05", 1'b1, 3'd0, 8'h05, 32'h123456AA, lat, nrd, nwr, flt);
        check_eq("SB05_mem", mem[1], 32'h8765AAF1);
        check_eq("SB05_lat", 32'(lat), 32'd3);
        check_eq("SB05_rdwr", {nrd[15:0], nwr[15:0]}, 32'h0001_0001);
        check_eq("SB05_rdata", rdata, 32'h00008765);
        do_access("SH06", 1'b1, 3'd1, 8'h06, 32'h0000BEEF, lat, nrd, nwr, flt);
        check_eq("SH06_mem", mem[1], 32'hBEEFAAF1);
        check_eq("SH06_lat", 32'(lat), 32'd3);

        // Word store and readback
        do_access("SW08", 1'b1, 3'd2, 8'h08, 32'hDEADBEEF, lat, nrd, nwr, flt);
        check_eq("SW08_mem", mem[2], 32'hDEADBEEF);
        check_eq("SW08_lat", 32'(lat), 32'd2);
        check_eq("SW08_rdwr", {nrd[15:0], nwr[15:0]}, 32'h0000_0001);
        do_access("LW08", 1'b0, 3'd2, 8'h08, 32'h0, lat, nrd, nwr, flt);
        check_eq("LW08_rdata", rdata, 32'hDEADBEEF);

        // Faults: {we, funct3, addr}
        do_access("fLW02", 1'b0, 3'd2, 8'h02, 32'h0, lat, nrd, nwr, flt);
        check_eq("fLW02", {flt, 7'd0, lat[7:0], nrd[7:0], nwr[7:0]}, 32'h80_01_00_00);
        do_access("fLH03", 1'b0, 3'd1, 8'h03, 32'h0, lat, nrd, nwr, flt);
        check_eq("fLH03", {flt, 7'd0, lat[7:0], nrd[7:0], nwr[7:0]}, 32'h80_01_00_00);
        do_access("fSH01", 1'b1, 3'd1, 8'h01, 32'h00001111, lat, nrd, nwr, flt);
        check_eq("fSH01", {flt, 7'd0, lat[7:0], nrd[7:0], nwr[7:0]}, 32'h80_01_00_00);
        do_access("fLD3", 1'b0, 3'd3, 8'h04, 32'h0, lat, nrd, nwr, flt);
        check_eq("fLD3", {flt, 7'd0, lat[7:0], nrd[7:0], nwr[7:0]}, 32'h80_01_00_00);
        check_eq("fault_rdata", rdata, 32'hDEADBEEF);
        check_eq("fault_mem0", mem[0], 32'h00000000);
        check_eq("fault_mem1", mem[1], 32'hBEEFAAF1);

        // req held high: LW 0x04 then SW 0x0C
        @(negedge clk);
        req = 1'b1; we = 1'b0; funct3 = 3'd2; addr = 8'h04; wdata = 32'h0;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            busy_tr[4-i] = busy;
            done_tr[4-i] = done;
            if (i == 1) begin
                we = 1'b1; funct3 = 3'd2; addr = 8'h0C; wdata = 32'hCAFEF00D;
            end
        end
        req = 1'b0;
        check_eq("held_busy", {27'd0, busy_tr}, 32'b10010);
        check_eq("held_done", {27'd0, done_tr}, 32'b01001);
        check_eq("held_rdata", rdata, 32'hBEEFAAF1);
        check_eq("held_mem3", mem[3], 32'hCAFEF00D);
        $display("txn held   LW 0x04 + SW 0x0C busy=%b done=%b mem[3]=%h", busy_tr, done_tr, mem[3]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
